syn_weight_access_ctrl: RTL and testbench

//  Sequences and arbitrates all traffic into the synapse weight table: the initial table load
//  (32-bit words), spike-driven 8-bit weight reads, and STDP read-modify-write updates.

---
 rtl/syn_weight_access_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_syn_weight_access_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/syn_weight_access_ctrl.sv
// -----------------------------------------------------------------------------
// syn_weight_access_ctrl
//
// Sequences and arbitrates all traffic into the synapse weight table:
//   - initial table load (one 32-bit word per accepted ld_valid/ld_ready beat),
//   - spike-driven 8-bit weight reads (rd_req/rd_gnt, data on rd_valid),
//   - STDP read-modify-write updates (up_req/up_gnt, write on up_done).
// This block is the sole driver of the memory port, so the weight memory can be
// a plain 1R1W byte-masked array with one cycle of read latency.
//
// Handshakes: a load word transfers on any cycle where ld_valid && ld_ready.
// rd_req/up_req are level requests held by the requester until the matching
// single-cycle grant; a request that is low in a cycle is never granted.
// rd_valid/up_done are single-cycle pulses with no back-pressure.
//
// Ports
//   clk, rst           clock, asynchronous active-low reset
//   ld_valid/ld_data   load stream in; ld_ready out; load_done sticky flag
//   rd_req/rd_addr     read request in; rd_gnt, rd_valid, rd_data out
//   up_req/up_addr/up_delta  update request in; up_gnt, up_done out
//   busy               FSM is out of reset and not in IDLE
//   mem_re/mem_raddr/mem_rdata             memory read port (1-cycle latency)
//   mem_we/mem_waddr/mem_wmask/mem_wdata   memory write port (byte enables)
//   dbg_state          current FSM state encoding
//
// Build option
//   SYN_STDP_SAT_EN    when defined, update results clamp to [0,255];
//                      otherwise they wrap modulo 256.
// -----------------------------------------------------------------------------
module syn_weight_access_ctrl #(
  parameter int N_WORDS    = 32,
  parameter int ADDR_W     = 7,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              load_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  input  logic              up_req,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic [7:0]        up_delta,
  output logic              up_gnt,
  output logic              up_done,
  output logic              busy,
  output logic              mem_re,
  output logic [ADDR_W-3:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_waddr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        dbg_state
);

  localparam int WORD_W = ADDR_W - 2;
  localparam int SCNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(N_WORDS - 1);
  localparam logic [SCNT_W-1:0] STARVE_LIM = SCNT_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_IDLE    = 3'd1,
    S_RD_WAIT = 3'd2,
    S_UP_RD   = 3'd3,
    S_UP_WR   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                active_q;
  logic [WORD_W-1:0]   ld_cnt_q, ld_cnt_d;
  logic                load_done_q, load_done_d;
  logic [SCNT_W-1:0]   starve_q, starve_d;
  logic [1:0]          rd_lane_q, rd_lane_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic [WORD_W-1:0]   up_word_q, up_word_d;
  logic [1:0]          up_lane_q, up_lane_d;
  logic [7:0]          up_delta_q, up_delta_d;
  logic [7:0]          up_new_q, up_new_d;

  logic                arb_ok;
  logic                grant_rd;
  logic                grant_up;
  logic [7:0]          old_byte;
  logic signed [9:0]   sum;

  // Sequential state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LOAD;
      active_q    <= 1'b0;
      ld_cnt_q    <= '0;
      load_done_q <= 1'b0;
      starve_q    <= '0;
      rd_lane_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      up_word_q   <= '0;
      up_lane_q   <= '0;
      up_delta_q  <= '0;
      up_new_q    <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= 1'b1;
      ld_cnt_q    <= ld_cnt_d;
      load_done_q <= load_done_d;
      starve_q    <= starve_d;
      rd_lane_q   <= rd_lane_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      up_word_q   <= up_word_d;
      up_lane_q   <= up_lane_d;
      up_delta_q  <= up_delta_d;
      up_new_q    <= up_new_d;
    end
  end

  // Arbitration is open in IDLE and in RD_WAIT: the read capture in RD_WAIT
  // uses only already-latched state, so a new grant can overlap it and reads
  // can be issued back to back.
  always_comb begin
    arb_ok   = (state_q == S_IDLE) || (state_q == S_RD_WAIT);
    grant_rd = 1'b0;
    grant_up = 1'b0;
    if (arb_ok) begin
      if (rd_req && (!up_req || (starve_q != STARVE_LIM))) begin
        grant_rd = 1'b1;
      end else if (up_req) begin
        grant_up = 1'b1;
      end
    end
  end

  // Weight arithmetic on the byte captured in UP_RD. The sum is kept in 10
  // signed bits so both underflow (negative) and overflow (>255) are visible.
  always_comb begin
    old_byte = mem_rdata[{up_lane_q, 3'b000} +: 8];
    sum      = $signed({2'b00, old_byte}) + $signed({{2{up_delta_q[7]}}, up_delta_q});
  end

  // Next-state and outputs
  always_comb begin
    state_d     = state_q;
    ld_cnt_d    = ld_cnt_q;
    load_done_d = load_done_q;
    starve_d    = starve_q;
    rd_lane_d   = rd_lane_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    up_word_d   = up_word_q;
    up_lane_d   = up_lane_q;
    up_delta_d  = up_delta_q;
    up_new_d    = up_new_q;

    ld_ready  = 1'b0;
    rd_gnt    = 1'b0;
    up_gnt    = 1'b0;
    up_done   = 1'b0;
    mem_re    = 1'b0;
    mem_raddr = '0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wmask = '0;
    mem_wdata = '0;

    case (state_q)
      S_LOAD: begin
        // active_q keeps ld_ready low while reset is asserted and for the
        // release cycle itself.
        if (active_q) begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            mem_we    = 1'b1;
            mem_waddr = ld_cnt_q;
            mem_wmask = 4'hF;
            mem_wdata = ld_data;
            if (ld_cnt_q == LAST_WORD) begin
              ld_cnt_d    = '0;
              load_done_d = 1'b1;
              state_d     = S_IDLE;
            end else begin
              ld_cnt_d = ld_cnt_q + WORD_W'(1);
            end
          end
        end
      end

      S_IDLE: begin
        state_d = S_IDLE;
      end

      S_RD_WAIT: begin
        rd_data_d  = mem_rdata[{rd_lane_q, 3'b000} +: 8];
        rd_valid_d = 1'b1;
        state_d    = S_IDLE;
      end

      S_UP_RD: begin
`ifdef SYN_STDP_SAT_EN
        if (sum[9]) begin
          up_new_d = 8'h00;
        end else if (sum[8]) begin
          up_new_d = 8'hFF;
        end else begin
          up_new_d = sum[7:0];
        end
`else
        up_new_d = sum[7:0];
`endif
        state_d = S_UP_WR;
      end

      S_UP_WR: begin
        mem_we    = 1'b1;
        mem_waddr = up_word_q;
        mem_wmask = 4'b0001 << up_lane_q;
        mem_wdata = {4{up_new_q}};
        up_done   = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase

    if (grant_rd) begin
      rd_gnt    = 1'b1;
      mem_re    = 1'b1;
      mem_raddr = rd_addr[ADDR_W-1:2];
      rd_lane_d = rd_addr[1:0];
      state_d   = S_RD_WAIT;
    end else if (grant_up) begin
      up_gnt     = 1'b1;
      mem_re     = 1'b1;
      mem_raddr  = up_addr[ADDR_W-1:2];
      up_word_d  = up_addr[ADDR_W-1:2];
      up_lane_d  = up_addr[1:0];
      up_delta_d = up_delta;
      state_d    = S_UP_RD;
    end

    // Starvation counter: counts reads that jumped ahead of a waiting update.
    if (!up_req || grant_up) begin
      starve_d = '0;
    end else if (grant_rd && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + SCNT_W'(1);
    end
  end

  assign load_done = load_done_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign busy      = active_q && (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_syn_weight_access_ctrl.sv
module tb_syn_weight_access_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        ld_valid = 1'b0;
  logic [31:0] ld_data  = '0;
  logic        ld_ready, load_done;
  logic        rd_req = 1'b0;
  logic [6:0]  rd_addr = '0;
  logic        rd_gnt, rd_valid;
  logic [7:0]  rd_data;
  logic        up_req = 1'b0;
  logic [6:0]  up_addr = '0;
  logic [7:0]  up_delta = '0;
  logic        up_gnt, up_done, busy;
  logic        mem_re;
  logic [4:0]  mem_raddr;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [2:0]  dbg_state;

  syn_weight_access_ctrl dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .load_done(load_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .up_req(up_req), .up_addr(up_addr), .up_delta(up_delta), .up_gnt(up_gnt), .up_done(up_done),
    .busy(busy), .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .dbg_state(dbg_state)
  );

  // Weight SRAM: byte-masked write, registered read.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (mem_re) mem_rdata <= mem[mem_raddr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  ref_w [128];
  logic [7:0]  exp_q [$];        // expected rd_data, in order
  int          rd_cyc_q [$];     // cycle in which rd_valid must appear
  logic [41:0] exp_wr_q [$];     // {up_done, waddr, wmask, wdata}
  int          wr_cyc_q [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] stdp_model(input logic [7:0] old, input logic [7:0] d);
    int s;
    s = int'(old) + int'($signed(d));
`ifdef SYN_STDP_SAT_EN
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return 8'(s);
`else
    return 8'(s & 255);
`endif
  endfunction

  // Monitor: pops expectations whenever the DUT presents a read result or write.
  always @(negedge clk) begin
    #3;
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rd_valid", 1, 0);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
        chk("rd_latency", cyc, rd_cyc_q.pop_front());
      end
    end
    if (mem_we || up_done) begin
      if (exp_wr_q.size() == 0) begin
        chk("unexpected_write", {up_done, mem_we}, 0);
      end else begin
        chk("mem_write", {up_done, mem_waddr, mem_wmask, mem_wdata}, exp_wr_q.pop_front());
        chk("write_cycle", cyc, wr_cyc_q.pop_front());
        chk("write_strobe", mem_we, 1);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_table(input bit hold_reqs);
    int gcount;
    bit acc;
    logic [31:0] w;
    gcount = 0;
    if (hold_reqs) begin
      @(negedge clk);
      rd_req = 1'b1; rd_addr = 7'd9; up_req = 1'b1; up_addr = 7'd9; up_delta = 8'd1;
    end
    for (int k = 0; k < 32; k++) begin
      w = 32'h03020100 + 32'h04040404 * 32'(k);
      for (int b = 0; b < 4; b++) ref_w[4*k+b] = w[8*b +: 8];
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(negedge clk);
        ld_valid = 1'b0;
        #1;
        if (rd_gnt || up_gnt) gcount++;
      end
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = w;
      acc = 1'b0;
      for (int c = 0; c < 20 && !acc; c++) begin
        #1;
        if (rd_gnt || up_gnt) gcount++;
        if (ld_ready) begin
          acc = 1'b1;
          exp_wr_q.push_back({1'b0, 5'(k), 4'hF, w});
          wr_cyc_q.push_back(cyc);
        end else begin
          @(negedge clk);
        end
      end
      if (!acc) chk("ld_ready_timeout", 0, 1);
    end
    @(negedge clk);
    ld_valid = 1'b0;
    rd_req = 1'b0;
    up_req = 1'b0;
    #1;
    chk("load_done_after_load", load_done, 1);
    chk("ld_ready_after_load", ld_ready, 0);
    chk("busy_after_load", busy, 0);
    if (hold_reqs) chk("grants_during_load", gcount, 0);
  endtask

  task automatic do_read(input logic [6:0] a, input bit use_e, input logic [7:0] e);
    bit got;
    @(negedge clk);
    rd_req = 1'b1;
    rd_addr = a;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (rd_gnt) begin
        got = 1'b1;
        exp_q.push_back(use_e ? e : ref_w[a]);
        rd_cyc_q.push_back(cyc + 2);
        chk("rd_mem_raddr", {mem_re, mem_raddr}, {1'b1, a[6:2]});
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("rd_gnt_timeout", 0, 1);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic push_update(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] nv;
    nv = stdp_model(ref_w[a], d);
    ref_w[a] = nv;
    exp_wr_q.push_back({1'b1, a[6:2], 4'b0001 << a[1:0], {4{nv}}});
    wr_cyc_q.push_back(cyc + 2);
  endtask

  task automatic do_update(input logic [6:0] a, input logic [7:0] d);
    bit got;
    @(negedge clk);
    up_req = 1'b1;
    up_addr = a;
    up_delta = d;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (up_gnt) begin
        got = 1'b1;
        chk("up_mem_raddr", {mem_re, mem_raddr}, {1'b1, a[6:2]});
        push_update(a, d);
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("up_gnt_timeout", 0, 1);
    @(negedge clk);
    up_req = 1'b0;
  endtask

  // Both requests held: reads may jump ahead at most 4 times.
  task automatic starve_run(input logic [6:0] ra, input logic [6:0] ua, input logic [7:0] d);
    int nrd;
    bit got_up;
    @(negedge clk);
    rd_req = 1'b1; rd_addr = ra;
    up_req = 1'b1; up_addr = ua; up_delta = d;
    nrd = 0;
    got_up = 1'b0;
    for (int c = 0; c < 40 && !got_up; c++) begin
      #1;
      if (rd_gnt) begin
        nrd++;
        exp_q.push_back(ref_w[ra]);
        rd_cyc_q.push_back(cyc + 2);
      end
      if (up_gnt) begin
        got_up = 1'b1;
        push_update(ua, d);
      end
      @(negedge clk);
    end
    up_req = 1'b0;
    rd_req = 1'b0;
    chk("starve_up_granted", got_up, 1);
    chk("starve_read_grants", nrd, 4);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit got;
    #1;
    chk("reset_ld_ready", ld_ready, 0);
    chk("reset_load_done", load_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_strobes", {mem_we, mem_re, rd_valid, up_done}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ld_ready_release_cycle", ld_ready, 0);
    @(negedge clk);
    #1;
    chk("ld_ready_after_release", ld_ready, 1);

    load_table(1'b1);

    // Directed read / update / re-read of synapse 5.
    do_read(7'd5, 1'b1, 8'h05);
    do_update(7'd5, 8'd3);
    do_read(7'd5, 1'b1, 8'h08);

    // Boundary arithmetic: 0xFE + 5 and 0x02 - 5.
    do_update(7'd127, 8'd127);
    do_read(7'd127, 1'b1, 8'hFE);
    do_update(7'd127, 8'd5);
`ifdef SYN_STDP_SAT_EN
    do_read(7'd127, 1'b1, 8'hFF);
`else
    do_read(7'd127, 1'b1, 8'h03);
`endif
    do_update(7'd2, 8'hFB);
`ifdef SYN_STDP_SAT_EN
    do_read(7'd2, 1'b1, 8'h00);
`else
    do_read(7'd2, 1'b1, 8'hFD);
`endif

    // Starvation limit, run twice to see the counter clear after the update.
    starve_run(7'd40, 7'd77, 8'd2);
    starve_run(7'd41, 7'd78, 8'hFE);
    do_read(7'd77, 1'b0, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_read(7'($urandom_range(0, 127)), 1'b0, 8'h00);
      else
        do_update(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
    end

    // Reset while an update sits in UP_RD: the write must never appear.
    repeat (4) @(negedge clk);
    up_req = 1'b1; up_addr = 7'd20; up_delta = 8'd9;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      #1;
      if (up_gnt) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) chk("midreset_up_gnt_timeout", 0, 1);
    @(negedge clk);
    up_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreset_outputs", {mem_we, up_done, busy, load_done, ld_ready}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_reset_load_done", load_done, 0);
    chk("post_reset_ld_ready", ld_ready, 0);
    @(negedge clk);
    #1;
    chk("post_reset_busy", busy, 1);
    load_table(1'b1);
    do_read(7'd20, 1'b1, 8'h14);
    do_read(7'd5, 1'b1, 8'h05);

    repeat (10) @(negedge clk);
    chk("rd_queue_drained", exp_q.size(), 0);
    chk("wr_queue_drained", exp_wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
